pipe_wb_stage: RTL and testbench
================================

// Module: pipe_wb_stage
// PURPOSE
//  Parametrised MEM->WB pipeline register for the vector ASIP datapath. Carries result, destination,
//  vector flag and write enable to the register-file write port, adding valid/ready backpressure,
//  synchronous flush, per-lane write masks and a forwarding lookup. SKID=1 gives a 2-entry skid buffer
//  so in_ready is registered (no combinational ready path from the register-file arbiter).
// PARAMETERS
//  DATA_W   128  result width in bits; must be a multiple of LANE_W
//  LANE_W   8    lane width in bits; LANES = DATA_W/LANE_W (default 16)
//  REG_AW   4    destination register index width
//  SKID     1    1 = 2-entry skid buffer, registered in_ready; 0 = single register, in_ready = !full | out_ready
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  flush        in   1        synchronous kill of all held entries
//  in_valid     in   1        upstream entry valid
//  in_ready     out  1        stage can accept this cycle
//  in_wreg      in   1        entry writes the register file
//  in_data      in   DATA_W   result
//  in_dest      in   REG_AW   destination register
//  in_vf        in   1        1 = vector register file, 0 = scalar
//  in_lane_mask in   LANES    per-lane write enable (vector only)
//  out_valid    out  1        head entry valid
//  out_ready    in   1        write port consumes head
//  out_wreg     out  1        head wreg & out_valid
//  out_data     out  DATA_W   head result
//  out_dest     out  REG_AW   head destination
//  out_vf       out  1        head vector flag
//  out_we_lane  out  LANES    effective lane write enables
//  lk_dest      in   REG_AW   forwarding lookup register
//  lk_vf        in   1        forwarding lookup file select
//  fwd_hit      out  1        a held entry will write lk_dest in file lk_vf
//  fwd_data     out  DATA_W   data of youngest matching entry
//  occupancy    out  2        entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - Reset: all outputs and stored payload 0; occupancy 0; in_ready 0 while rst high, 1 first cycle after.
//  - Transfer in on in_valid&in_ready, out on out_valid&out_ready, both at posedge; latency 1 cycle
//    (accepted at edge N -> out_valid after edge N when stage was empty).
//  - SKID=1 states EMPTY/ONE/TWO: EMPTY+in->ONE; ONE+in&!out->TWO; ONE+in&out->ONE; ONE+out&!in->EMPTY;
//    TWO+out->ONE (skid entry promotes to head); TWO never accepts. in_ready = (state!=TWO), registered.
//  - SKID=0: single entry; in_ready = !out_valid | out_ready (combinational pass-through allowed).
//  - Ordering strictly FIFO; no entry dropped or duplicated under any valid/ready pattern.
//  - Lane mask: stored as presented if in_vf=1; if in_vf=0 forced to lane 0 only (LANES'b1).
//    out_we_lane = stored mask & {LANES{out_wreg}}.
//  - Payload regs hold last value when out_valid=0; out_wreg and out_we_lane are 0 then.
//  - flush: next state EMPTY, occupancy 0, out_valid 0; beats a same-cycle accept or drain (accepted
//    entry is discarded); payload data not cleared. in_ready 1 on cycle after flush.
//  - Forwarding (combinational): match = valid & wreg & dest==lk_dest & vf==lk_vf & |mask.
//    Skid entry is younger than head; youngest match wins for fwd_data. fwd_hit 0 -> fwd_data = 0.
//    In-flight input (in_valid this cycle) is not searched.
//  - rst mid-operation: all entries lost immediately (async), no partial write emitted.
// STRUCTURE
//  - Package wb_pkg: LANE_W default, wb_payload_t {wreg, data, dest, vf, lane_mask}, function
//    scalar_mask() returning lane-0-only mask; state enum {WB_EMPTY, WB_ONE, WB_TWO}.
//  - One sub-module: wb_skid_buf (2-entry head/skid storage + state), instantiated when SKID=1;
//    top holds mask normalisation, output gating and forwarding lookup.
// TESTING
//  1 Reset: assert rst mid-traffic -> all outputs 0, occupancy 0; release -> in_ready=1 next cycle.
//  2 Streaming out_ready=1: 8 back-to-back vector writes dest 0..7 -> emerge in order, 1-cycle latency, no bubbles.
//  3 Backpressure SKID=1: out_ready=0, push A,B -> occupancy 2, in_ready 0; out_ready=1 -> A then B, ready back.
//  4 Scalar mask: in_vf=0, in_lane_mask=16'hFFFF, wreg=1 -> out_we_lane=16'h0001; vector keeps 16'hF0F0.
//  5 Forwarding: head dest 3 data 0x11.., skid dest 3 data 0x22.., lk_dest=3 lk_vf=1 -> hit, 0x22..; lk_vf=0 -> miss.
//  6 Flush with in_valid&in_ready and occupancy 1 -> next cycle occupancy 0, out_valid 0, nothing emitted.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the MEM->WB stage: default geometry, payload layout, buffer states.
// No logic, so no latency or backpressure of its own.
package wb_pkg;
    localparam int WB_DATA_W = 128;
    localparam int WB_LANE_W = 8;
    localparam int WB_REG_AW = 4;
    localparam int WB_LANES  = WB_DATA_W / WB_LANE_W;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_ONE   = 2'd1,
        WB_TWO   = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                 wreg;
        logic [WB_DATA_W-1:0] data;
        logic [WB_REG_AW-1:0] dest;
        logic                 vf;
        logic [WB_LANES-1:0]  lane_mask;
    } wb_payload_t;

    function automatic logic [WB_LANES-1:0] scalar_mask();
        return {{(WB_LANES-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry head/skid buffer for an opaque payload; latency 1 cycle.
// in_ready is a flop that drops only while both entries are held.
module wb_skid_buf
    import wb_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_pay,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pay,
    output logic          skid_valid,
    output logic [PW-1:0] skid_pay,
    output logic [1:0]    occupancy
);
    wb_state_t     state, state_nxt;
    logic [PW-1:0] head_q, skid_q;
    logic          rdy_q, head_ld, head_from_skid, skid_ld, accept, drain;

    assign accept = in_valid & rdy_q;
    assign drain  = (state != WB_EMPTY) & out_ready;

    always_comb begin
        state_nxt      = state;
        head_ld        = 1'b0;
        head_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state)
            WB_EMPTY: begin
                if (accept) begin
                    state_nxt = WB_ONE;
                    head_ld   = 1'b1;
                end
            end
            WB_ONE: begin
                if (accept && drain) begin
                    head_ld = 1'b1;
                end else if (accept) begin
                    state_nxt = WB_TWO;
                    skid_ld   = 1'b1;
                end else if (drain) begin
                    state_nxt = WB_EMPTY;
                end
            end
            WB_TWO: begin
                if (drain) begin
                    state_nxt      = WB_ONE;
                    head_ld        = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nxt = WB_EMPTY;
        endcase
        // Flush wins over any same-cycle accept or drain; stored payload is left alone.
        if (flush) begin
            state_nxt = WB_EMPTY;
            head_ld   = 1'b0;
            skid_ld   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= WB_EMPTY;
            rdy_q  <= 1'b0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != WB_TWO);
            if (head_ld) head_q <= head_from_skid ? skid_q : in_pay;
            if (skid_ld) skid_q <= in_pay;
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = (state != WB_EMPTY);
    assign out_pay    = head_q;
    assign skid_valid = (state == WB_TWO);
    assign skid_pay   = skid_q;
    assign occupancy  = (state == WB_TWO) ? 2'd2 : (state == WB_ONE) ? 2'd1 : 2'd0;
endmodule

// File: rtl/pipe_wb_stage.sv
// MEM->WB pipeline register with lane masks and forwarding lookup; latency 1 cycle.
// SKID=1: registered in_ready via 2-entry skid buffer; SKID=0: single entry, ready passes through.
module pipe_wb_stage
    import wb_pkg::*;
#(
    parameter  int DATA_W = WB_DATA_W,
    parameter  int LANE_W = WB_LANE_W,
    parameter  int REG_AW = WB_REG_AW,
    parameter  int SKID   = 1,
    localparam int LANES  = DATA_W / LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wreg,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_vf,
    input  logic [LANES-1:0]  in_lane_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wreg,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_vf,
    output logic [LANES-1:0]  out_we_lane,
    input  logic [REG_AW-1:0] lk_dest,
    input  logic              lk_vf,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy
);
    typedef struct packed {
        logic              wreg;
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] dest;
        logic              vf;
        logic [LANES-1:0]  lane_mask;
    } pay_t;

    pay_t in_pay, head_pay, skid_pay;
    logic head_vld, skid_vld, head_match, skid_match;

    // Scalar writes only ever touch lane 0, whatever mask upstream presents.
    always_comb begin
        in_pay.wreg      = in_wreg;
        in_pay.data      = in_data;
        in_pay.dest      = in_dest;
        in_pay.vf        = in_vf;
        in_pay.lane_mask = in_vf ? in_lane_mask : LANES'(scalar_mask());
    end

    generate
        if (SKID != 0) begin : g_skid
            wb_skid_buf #(.PW($bits(pay_t))) u_buf (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .in_valid   (in_valid),
                .in_ready   (in_ready),
                .in_pay     (in_pay),
                .out_valid  (head_vld),
                .out_ready  (out_ready),
                .out_pay    (head_pay),
                .skid_valid (skid_vld),
                .skid_pay   (skid_pay),
                .occupancy  (occupancy)
            );
        end else begin : g_single
            logic full_q;
            pay_t hold_q;

            assign in_ready = !rst && (!full_q || out_ready);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    full_q <= 1'b0;
                    hold_q <= '0;
                end else if (flush) begin
                    full_q <= 1'b0;
                end else if (in_valid && in_ready) begin
                    full_q <= 1'b1;
                    hold_q <= in_pay;
                end else if (out_ready) begin
                    full_q <= 1'b0;
                end
            end

            assign head_vld  = full_q;
            assign head_pay  = hold_q;
            assign skid_vld  = 1'b0;
            assign skid_pay  = '0;
            assign occupancy = {1'b0, full_q};
        end
    endgenerate

    assign out_valid   = head_vld;
    assign out_wreg    = head_vld & head_pay.wreg;
    assign out_data    = head_pay.data;
    assign out_dest    = head_pay.dest;
    assign out_vf      = head_pay.vf;
    assign out_we_lane = head_pay.lane_mask & {LANES{out_wreg}};

    assign head_match = head_vld & head_pay.wreg & (head_pay.dest == lk_dest) &
                        (head_pay.vf == lk_vf) & (|head_pay.lane_mask);
    assign skid_match = skid_vld & skid_pay.wreg & (skid_pay.dest == lk_dest) &
                        (skid_pay.vf == lk_vf) & (|skid_pay.lane_mask);

    // The skid entry is the younger one, so it shadows the head.
    assign fwd_hit  = head_match | skid_match;
    assign fwd_data = skid_match ? skid_pay.data : head_match ? head_pay.data : '0;
endmodule

// File: tb/tb_pipe_wb_stage.sv
// Randomized plus directed bench for pipe_wb_stage (SKID=1), checked against a queue model.
module tb_pipe_wb_stage;
    localparam int DW = 128;
    localparam int LN = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, in_wreg, in_vf;
    logic [DW-1:0] in_data, out_data, fwd_data;
    logic [AW-1:0] in_dest, out_dest, lk_dest;
    logic [LN-1:0] in_lane_mask, out_we_lane;
    logic          out_valid, out_ready, out_wreg, out_vf, lk_vf, fwd_hit;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    pipe_wb_stage #(.DATA_W(DW), .LANE_W(8), .REG_AW(AW), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_wreg(in_wreg), .in_data(in_data),
        .in_dest(in_dest), .in_vf(in_vf), .in_lane_mask(in_lane_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_wreg(out_wreg), .out_data(out_data),
        .out_dest(out_dest), .out_vf(out_vf), .out_we_lane(out_we_lane),
        .lk_dest(lk_dest), .lk_vf(lk_vf), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .occupancy(occupancy)
    );

    typedef struct packed {
        logic          wreg;
        logic [DW-1:0] data;
        logic [AW-1:0] dest;
        logic          vf;
        logic [LN-1:0] mask;
    } ent_t;

    ent_t q[$];
    ent_t last_head;
    logic rdy_exp;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic          hit;
        logic [DW-1:0] fd;
        logic          busy;
        busy = (q.size() != 0);
        if (busy) last_head = q[0];
        hit = 1'b0;
        fd  = '0;
        foreach (q[i])
            if (q[i].wreg && q[i].dest == lk_dest && q[i].vf == lk_vf && q[i].mask != '0) begin
                hit = 1'b1;
                fd  = q[i].data;
            end
        chk("in_ready",    in_ready,    rdy_exp);
        chk("occupancy",   occupancy,   q.size());
        chk("out_valid",   out_valid,   busy);
        chk("out_wreg",    out_wreg,    busy & last_head.wreg);
        chk("out_data",    out_data,    last_head.data);
        chk("out_dest",    out_dest,    last_head.dest);
        chk("out_vf",      out_vf,      last_head.vf);
        chk("out_we_lane", out_we_lane, (busy && last_head.wreg) ? last_head.mask : '0);
        chk("fwd_hit",     fwd_hit,     hit);
        chk("fwd_data",    fwd_data,    fd);
    endtask

    // Inputs are set at the falling edge; the model advances at the rising edge.
    task automatic step();
        logic acc, drn;
        ent_t e;
        #1 check_all();
        @(posedge clk);
        acc = in_valid && rdy_exp;
        drn = (q.size() != 0) && out_ready;
        e   = '{wreg: in_wreg, data: in_data, dest: in_dest, vf: in_vf,
                mask: in_vf ? in_lane_mask : 16'h0001};
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        rdy_exp = (q.size() < 2);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic w, input logic [DW-1:0] d, input logic [AW-1:0] de,
                         input logic vf, input logic [LN-1:0] m, input logic ordy, input logic fl);
        in_valid = v; in_wreg = w; in_data = d; in_dest = de;
        in_vf = vf; in_lane_mask = m; out_ready = ordy; flush = fl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        last_head = '0;
        rdy_exp   = 1'b0;
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [DW-1:0] a, b;
        drive(0, 0, '0, '0, 0, '0, 0, 0);
        lk_dest = '0;
        lk_vf   = 1'b0;
        do_reset();

        // Back-to-back vector writes with the sink always ready.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, rnd_data(), 4'(i), 1, 16'($urandom()), 1, 0);
            step();
        end
        drive(0, 0, '0, '0, 0, '0, 1, 0);
        step();
        step();

        // Backpressure fills both entries, then drains in order.
        a = rnd_data();
        b = rnd_data();
        drive(1, 1, a, 4'd5, 1, 16'hFFFF, 0, 0); step();
        drive(1, 1, b, 4'd6, 1, 16'h00FF, 0, 0); step();
        drive(0, 0, '0, '0, 0, '0, 0, 0);
        #1 chk("bp_occupancy", occupancy, 2'd2);
        chk("bp_in_ready", in_ready, 1'b0);
        step();
        out_ready = 1'b1;
        #1 chk("bp_first", out_data, a);
        step();
        #1 chk("bp_second", out_data, b);
        step();
        #1 chk("bp_ready_back", in_ready, 1'b1);
        step();

        // Scalar entries write lane 0 only; vector masks pass through.
        drive(1, 1, rnd_data(), 4'd2, 0, 16'hFFFF, 0, 0); step();
        drive(0, 0, '0, '0, 0, '0, 0, 0);
        #1 chk("scalar_mask", out_we_lane, 16'h0001);
        drive(1, 1, rnd_data(), 4'd2, 1, 16'hF0F0, 1, 0); step();
        drive(0, 0, '0, '0, 0, '0, 0, 0);
        #1 chk("vector_mask", out_we_lane, 16'hF0F0);
        out_ready = 1'b1;
        step();

        // Youngest matching entry supplies forwarded data.
        drive(1, 1, {16{8'h11}}, 4'd3, 1, 16'hFFFF, 0, 0); step();
        drive(1, 1, {16{8'h22}}, 4'd3, 1, 16'hFFFF, 0, 0); step();
        drive(0, 0, '0, '0, 0, '0, 0, 0);
        lk_dest = 4'd3;
        lk_vf   = 1'b1;
        #1 chk("fwd_hit_young", fwd_hit, 1'b1);
        chk("fwd_data_young", fwd_data, {16{8'h22}});
        step();
        lk_vf = 1'b0;
        #1 chk("fwd_miss_vf", fwd_hit, 1'b0);
        chk("fwd_miss_data", fwd_data, '0);
        out_ready = 1'b1;
        step();
        step();

        // Flush beats a simultaneous accept and drain.
        drive(1, 1, rnd_data(), 4'd9, 1, 16'h0F0F, 0, 0); step();
        drive(1, 1, rnd_data(), 4'd10, 1, 16'hFFFF, 1, 1); step();
        drive(0, 0, '0, '0, 0, '0, 1, 0);
        #1 chk("flush_occupancy", occupancy, 2'd0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        step();

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rnd_data(),
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom()),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            lk_dest = 4'($urandom_range(0, 3));
            lk_vf   = 1'($urandom_range(0, 1));
            if (i == 200) begin
                do_reset();
                step();
                #1 chk("rst_release_ready", in_ready, 1'b1);
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
